// File: rtl/layer3_pkg.sv
// Shared constants and width helper for the Layer3 partial-sum datapath.
package layer3_pkg;

    localparam int PSUM_W = 8;

    // Accumulator width that holds tile_num sums of data_w-bit values, with one spare bit.
    function automatic int acc_width(input int data_w, input int tile_num);
        return data_w + $clog2(tile_num) + 1;
    endfunction

endpackage

// File: rtl/tile_acc_lane.sv
// One output channel's tile accumulator; result registered 1 cycle after the last tile, no backpressure.
// Adds a per-lane threshold comparator when TILE_ACCUMULATE_BIN_EN is defined.
module tile_acc_lane #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld,
    input  logic              first,
    input  logic              last,
    input  logic [DATA_W-1:0] data_in,
`ifdef TILE_ACCUMULATE_BIN_EN
    input  logic [ACC_W-1:0]  thresh,
    output logic              bin_out,
`endif
    output logic [ACC_W-1:0]  data_out
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] data_out_q, data_out_d;
    logic [ACC_W-1:0] sum;
`ifdef TILE_ACCUMULATE_BIN_EN
    logic             bin_q, bin_d;
`endif

    always_comb begin
        // First tile of a group loads rather than adds, so no stale carry survives a restart.
        sum        = (first ? '0 : acc_q) + ACC_W'(data_in);
        acc_d      = acc_q;
        data_out_d = data_out_q;
`ifdef TILE_ACCUMULATE_BIN_EN
        bin_d      = bin_q;
`endif
        if (vld) begin
            acc_d = sum;
            if (last) begin
                data_out_d = sum;
`ifdef TILE_ACCUMULATE_BIN_EN
                bin_d      = (sum >= thresh);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            data_out_q <= '0;
`ifdef TILE_ACCUMULATE_BIN_EN
            bin_q      <= 1'b0;
`endif
        end else begin
            acc_q      <= acc_d;
            data_out_q <= data_out_d;
`ifdef TILE_ACCUMULATE_BIN_EN
            bin_q      <= bin_d;
`endif
        end
    end

    assign data_out = data_out_q;
`ifdef TILE_ACCUMULATE_BIN_EN
    assign bin_out  = bin_q;
`endif

endmodule

// File: rtl/tile_accumulate.sv
// Sums TILE_NUM partial-sum vectors per output channel; result 1 cycle after last tile, no backpressure.
// Optional thresholded bin_out under TILE_ACCUMULATE_BIN_EN.
module tile_accumulate
    import layer3_pkg::*;
#(
    parameter int  CHANNEL_NUM = 128,
    parameter int  TILE_NUM    = 4,
    parameter int  DATA_W      = PSUM_W,
    localparam int ACC_W       = acc_width(DATA_W, TILE_NUM),
    localparam int CNT_W       = $clog2(TILE_NUM + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   data_in_valid,
    input  logic [DATA_W-1:0]      data_in [CHANNEL_NUM],
`ifdef TILE_ACCUMULATE_BIN_EN
    input  logic [ACC_W-1:0]       thresh [CHANNEL_NUM],
    output logic [CHANNEL_NUM-1:0] bin_out,
`endif
    output logic                   data_out_valid,
    output logic [ACC_W-1:0]       data_out [CHANNEL_NUM],
    output logic                   busy,
    output logic [CNT_W-1:0]       tile_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TILE_NUM - 1);

    logic [CNT_W-1:0] tile_cnt_q, tile_cnt_d;
    logic [CNT_W-1:0] cur_cnt;
    logic             first_tile, last_tile;
    logic             valid_q, valid_d;

    always_comb begin
        // frame_start clears before the same-cycle valid is counted.
        cur_cnt    = frame_start ? '0 : tile_cnt_q;
        first_tile = (cur_cnt == '0);
        last_tile  = (cur_cnt == LAST_CNT);
        tile_cnt_d = cur_cnt;
        valid_d    = 1'b0;
        if (data_in_valid) begin
            valid_d    = last_tile;
            tile_cnt_d = last_tile ? '0 : cur_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tile_cnt_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            tile_cnt_q <= tile_cnt_d;
            valid_q    <= valid_d;
        end
    end

    assign tile_cnt       = tile_cnt_q;
    assign busy           = (tile_cnt_q != '0);
    assign data_out_valid = valid_q;

    for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_lane
        tile_acc_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .vld      (data_in_valid),
            .first    (first_tile),
            .last     (last_tile),
            .data_in  (data_in[g]),
`ifdef TILE_ACCUMULATE_BIN_EN
            .thresh   (thresh[g]),
            .bin_out  (bin_out[g]),
`endif
            .data_out (data_out[g])
        );
    end

endmodule
